// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial 0010 pattern transmitter: state encoding,
// default pattern and the bit-counter width helper.
package seq_gen_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_SEND = ST_SEND,
    S_GAP  = ST_GAP
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b0010;

  // Wide enough to index every pattern bit plus the optional parity slot.
  function automatic int bit_cnt_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_gen_0010.sv
// Serial pattern transmitter: a start pulse sends (repeat_cnt+1) copies of PATTERN,
// MSB first, with gap idle cycles between copies. Define SEQ_GEN_PARITY_EN to append an even-parity bit per copy.
module seq_gen_0010
  import seq_gen_pkg::*;
#(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PATTERN  = DEFAULT_PATTERN,
  parameter int               CNT_W    = 4,
  parameter int               GAP_W    = 3,
  parameter logic             IDLE_LVL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only in IDLE (ignored, not queued, while busy);
  // busy rises the cycle after accept and drops in the single done cycle, which
  // is itself IDLE and may accept the next start.

  localparam int BC_W = bit_cnt_w(PAT_W);

`ifdef SEQ_GEN_PARITY_EN
  localparam logic [BC_W-1:0] LAST_IDX   = BC_W'(PAT_W);
  localparam logic [BC_W-1:0] PAR_IDX    = BC_W'(PAT_W - 1);
  localparam logic            PARITY_BIT = ^PATTERN;
`else
  localparam logic [BC_W-1:0] LAST_IDX   = BC_W'(PAT_W - 1);
`endif

  state_t           state, state_n;
  logic [PAT_W-1:0] shreg, shreg_n;
  logic [BC_W-1:0]  bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0] rep_cnt, rep_cnt_n;
  logic [GAP_W-1:0] gap_ld, gap_ld_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic             out_n, out_valid_n, busy_n, done_n;
  logic             load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      rep_cnt   <= '0;
      gap_ld    <= '0;
      gap_cnt   <= '0;
      out       <= IDLE_LVL;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      rep_cnt   <= rep_cnt_n;
      gap_ld    <= gap_ld_n;
      gap_cnt   <= gap_cnt_n;
      out       <= out_n;
      out_valid <= out_valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Outputs are computed for the next cycle and registered, so bit_cnt is the
  // index of the bit currently on out and shreg holds the bits still to come.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    bit_cnt_n   = bit_cnt;
    rep_cnt_n   = rep_cnt;
    gap_ld_n    = gap_ld;
    gap_cnt_n   = gap_cnt;
    out_n       = IDLE_LVL;
    out_valid_n = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    load        = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          rep_cnt_n = repeat_cnt;
          gap_ld_n  = gap;
          load      = 1'b1;
        end
      end

      S_SEND: begin
        if (bit_cnt != LAST_IDX) begin
          busy_n      = 1'b1;
          out_valid_n = 1'b1;
          bit_cnt_n   = bit_cnt + BC_W'(1);
`ifdef SEQ_GEN_PARITY_EN
          if (bit_cnt == PAR_IDX) begin
            out_n = PARITY_BIT;
          end else begin
            out_n   = shreg[PAT_W-1];
            shreg_n = shreg << 1;
          end
`else
          out_n   = shreg[PAT_W-1];
          shreg_n = shreg << 1;
`endif
        end else if (rep_cnt == '0) begin
          state_n   = S_IDLE;
          bit_cnt_n = '0;
          done_n    = 1'b1;
        end else if (gap_ld != '0) begin
          state_n   = S_GAP;
          bit_cnt_n = '0;
          gap_cnt_n = '0;
          busy_n    = 1'b1;
        end else begin
          load      = 1'b1;
          rep_cnt_n = rep_cnt - CNT_W'(1);
        end
      end

      S_GAP: begin
        busy_n = 1'b1;
        if (gap_cnt == gap_ld - GAP_W'(1)) begin
          load      = 1'b1;
          gap_cnt_n = '0;
          rep_cnt_n = rep_cnt - CNT_W'(1);
        end else begin
          gap_cnt_n = gap_cnt + GAP_W'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase

    // Common (re)load path: first bit goes out immediately, the rest are shifted.
    if (load) begin
      state_n     = S_SEND;
      shreg_n     = PATTERN << 1;
      bit_cnt_n   = '0;
      out_n       = PATTERN[PAT_W-1];
      out_valid_n = 1'b1;
      busy_n      = 1'b1;
    end
  end

  assign state_dbg = state;

endmodule
